// File: rtl/timer_input_mux2x1.sv
// timer_input_mux2x1: two-way selector for the timer-input path.
// Provides the selected value combinationally and as a registered copy,
// plus a one-cycle flag when the registered select changes source.
module timer_input_mux2x1 #(
   parameter int unsigned WIDTH     = 1,
   parameter bit          RESET_SEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_q,
   output logic             sel_q,
   output logic             switched
);

   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] data_q;
   logic             src_d;
   logic             src_q;
   logic             switched_d;
   logic             switched_q;

   // Select the source and detect a change against the stored select.
   always_comb begin
      data_d     = a;
      src_d      = sel;
      switched_d = 1'b0;
      if (sel) begin
         data_d = b;
      end
      if (sel != src_q) begin
         switched_d = 1'b1;
      end
   end

   // Registered copies; synchronous reset wins over every update.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q     <= '0;
         src_q      <= RESET_SEL;
         switched_q <= 1'b0;
      end else begin
         data_q     <= data_d;
         src_q      <= src_d;
         switched_q <= switched_d;
      end
   end

   // The combinational output ignores clk and rst, so it stays valid in reset.
   assign out      = data_d;
   assign out_q    = data_q;
   assign sel_q    = src_q;
   assign switched = switched_q;

endmodule

// File: tb/tb_timer_input_mux2x1.sv
// Directed bench for timer_input_mux2x1: truth table, reset, switch
// detection, 8-bit passthrough, mid-operation reset and RESET_SEL=1.
module tb_timer_input_mux2x1;

   logic       clk;
   logic       rst;
   logic       a1, b1, sel1;
   logic       out1, out_q1, sel_q1, sw1;
   logic [7:0] a8, b8;
   logic       sel8;
   logic [7:0] out8, out_q8;
   logic       sel_q8, sw8;
   logic       ar, br, selr;
   logic       outr, out_qr, sel_qr, swr;

   int vectors;
   int miscompares;

   timer_input_mux2x1 #(.WIDTH(1), .RESET_SEL(1'b0)) u_w1 (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .sel(sel1),
      .out(out1), .out_q(out_q1), .sel_q(sel_q1), .switched(sw1)
   );

   timer_input_mux2x1 #(.WIDTH(8), .RESET_SEL(1'b0)) u_w8 (
      .clk(clk), .rst(rst), .a(a8), .b(b8), .sel(sel8),
      .out(out8), .out_q(out_q8), .sel_q(sel_q8), .switched(sw8)
   );

   timer_input_mux2x1 #(.WIDTH(1), .RESET_SEL(1'b1)) u_rs1 (
      .clk(clk), .rst(rst), .a(ar), .b(br), .sel(selr),
      .out(outr), .out_q(out_qr), .sel_q(sel_qr), .switched(swr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic tt_a   [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   logic tt_b   [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   logic tt_s   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   logic tt_exp [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
   logic sw_sel [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   logic sw_exp [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst  = 1'b1;
      a1   = 1'b1; b1 = 1'b1; sel1 = 1'b1;
      a8   = 8'h00; b8 = 8'h00; sel8 = 1'b0;
      ar   = 1'b1; br = 1'b0; selr = 1'b0;

      // Reset held for two edges; out stays combinational throughout.
      #1;
      chk("rst_out_pre", 8'(out1), 8'h01);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_out_q", 8'(out_q1), 8'h00);
         chk("rst_sel_q", 8'(sel_q1), 8'h00);
         chk("rst_switched", 8'(sw1), 8'h00);
         chk("rst_out", 8'(out1), 8'h01);
         chk("rst_rs1_sel_q", 8'(sel_qr), 8'h01);
      end

      // Truth table: out immediately, out_q one edge later.
      rst = 1'b0;
      for (int i = 0; i < 7; i++) begin
         a1 = tt_a[i]; b1 = tt_b[i]; sel1 = tt_s[i];
         #1;
         chk($sformatf("tt_out_%0d", i), 8'(out1), 8'(tt_exp[i]));
         tick();
         chk($sformatf("tt_out_q_%0d", i), 8'(out_q1), 8'(tt_exp[i]));
         if (i == 0) begin
            chk("rs1_first_switched", 8'(swr), 8'h01);
            chk("rs1_first_sel_q", 8'(sel_qr), 8'h00);
         end
         if (i == 1) begin
            chk("rs1_second_switched", 8'(swr), 8'h00);
         end
      end

      // Switch detection from a clean reset.
      rst = 1'b1;
      tick();
      chk("sw_rst_sel_q", 8'(sel_q1), 8'h00);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         sel1 = sw_sel[i];
         tick();
         chk($sformatf("sw_switched_%0d", i), 8'(sw1), 8'(sw_exp[i]));
         chk($sformatf("sw_sel_q_%0d", i), 8'(sel_q1), 8'(sw_sel[i]));
      end

      // Toggling every cycle keeps switched high.
      for (int i = 0; i < 3; i++) begin
         sel1 = ~sel1;
         tick();
         chk($sformatf("toggle_switched_%0d", i), 8'(sw1), 8'h01);
      end

      // 8-bit passthrough.
      a8 = 8'hA5; b8 = 8'h3C; sel8 = 1'b0;
      #1;
      chk("w8_out_a", out8, 8'hA5);
      tick();
      chk("w8_out_q_a", out_q8, 8'hA5);
      sel8 = 1'b1;
      #1;
      chk("w8_out_b", out8, 8'h3C);
      tick();
      chk("w8_out_q_b", out_q8, 8'h3C);
      chk("w8_switched", 8'(sw8), 8'h01);
      // Simultaneous change of a, b and sel: new source only.
      a8 = 8'h0F; b8 = 8'hF0; sel8 = 1'b0;
      tick();
      chk("w8_simul_out_q", out_q8, 8'h0F);

      // Mid-operation reset.
      a1 = 1'b1; b1 = 1'b0; sel1 = 1'b0;
      tick();
      tick();
      chk("mid_pre_out_q", 8'(out_q1), 8'h01);
      rst = 1'b1;
      tick();
      chk("mid_rst_out_q", 8'(out_q1), 8'h00);
      chk("mid_rst_switched", 8'(sw1), 8'h00);
      chk("mid_rst_out", 8'(out1), 8'h01);
      rst = 1'b0;
      tick();
      chk("mid_release_out_q", 8'(out_q1), 8'h01);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/timer_input_mux2x1.md
Name: timer_input_mux2x1

Overview:
Two-way input selector for the microwave controller's timer-input path. It chooses between source A and source B under `sel`, in the same manner as the plain Mux2x1. It provides the selected value combinationally, and also as a registered, reset-clean copy for downstream timer logic. It also flags cycles where the registered selection switches source, so downstream logic can discard stale data.

Parameters:
WIDTH, 1, bit width of a, b, out and out_q (must be >= 1)
RESET_SEL, 0, value loaded into the internal select register on reset (0 = source A, 1 = source B)

Ports:
clk  input  1  system clock, all registers on rising edge
rst  input  1  synchronous active-high reset
a  input  WIDTH  source A data
b  input  WIDTH  source B data
sel  input  1  source select: 0 -> a, 1 -> b
out  output  WIDTH  combinational selected value
out_q  output  WIDTH  registered selected value
sel_q  output  1  registered copy of sel
switched  output  1  one-cycle pulse when sel_q changes value

Behaviour:
Interface: one clock; reset is synchronous and active-high (clk, rst).

Combinational path:
- out = (sel == 0) ? a : b.
- Pure combinational, zero latency, independent of clk and rst. It stays valid during reset.
- Any change on a, b or sel propagates to out within the same delta/cycle.
- Required truth (WIDTH=1): a=0,b=0,sel=0 -> 0; a=0,b=1,sel=0 -> 0; a=1,b=1,sel=0 -> 1; a=1,b=0,sel=0 -> 1; a=1,b=0,sel=1 -> 0; a=1,b=1,sel=1 -> 1; a=0,b=1,sel=1 -> 1.
- X/Z on sel: out is don't-care. No X-pessimism handling is required.

Registered path (rising clk):
- rst=1 sets: out_q <= 0 (all bits), sel_q <= RESET_SEL, switched <= 0. Reset has priority over all other updates.
- rst=0 updates:
  - out_q <= (sel ? b : a), one-cycle latency from the inputs.
  - sel_q <= sel.
  - switched <= (sel != sel_q). It pulses exactly one cycle after the edge where sel first differs from the stored sel_q.
- If sel toggles every cycle, switched stays high continuously. Each cycle is a genuine switch.
- Reset asserted mid-operation: the next edge clears the registers regardless of inputs.
- The first edge after reset release compares sel against RESET_SEL. A mismatch yields switched=1 on that cycle.
- Simultaneous change of a, b and sel on one cycle: out_q takes the newly selected source's value at that edge. No mixing of old and new.
- Arithmetic: none. Bits pass through unchanged, with no sign or width extension.

Test Plan:
- WIDTH=1, rst=0: apply the seven truth-table vectors above, 10 time units apart -> out matches each listed value immediately. out_q matches it one clk edge later.
- Reset: hold rst=1 for 2 cycles with a=1,b=1,sel=1 -> out_q=0, sel_q=RESET_SEL (0), switched=0. out=1 throughout reset.
- Switch detect: after reset (sel_q=0), drive sel 0,0,1,1,0 on consecutive edges -> switched 0,0,1,0,1 one cycle behind. sel_q follows sel with 1-cycle delay.
- WIDTH=8: a=8'hA5, b=8'h3C; sel=0 -> out=8'hA5. sel=1 -> out=8'h3C. out_q follows after one edge with no bit corruption.
- Mid-operation reset: with a=1,sel=0 and out_q=1, assert rst for one cycle -> out_q=0 and switched=0 at that edge. Release -> out_q=1 on the following edge.
- RESET_SEL=1: reset, then hold sel=0 -> switched=1 on the first post-reset edge, then 0.
